// File: rtl/nn_input_stage.sv
// rtl/nn_input_stage.sv - byte-stream front-end assembling 4-sample frames into signed input vectors
module nn_input_stage #(
    parameter int OFFSET = 128,
    parameter int ERRW   = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [7:0]              s_data,
    input  logic                    s_valid,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic signed [8:0]       x0,
    output logic signed [8:0]       x1,
    output logic signed [8:0]       x2,
    output logic signed [8:0]       x3,
    output logic                    m_valid,
    input  logic                    m_ready,
    input  logic                    err_clr,
    output logic                    err,
    output logic [ERRW-1:0]         err_cnt
);

    typedef enum logic [1:0] {
        ST_COLLECT,
        ST_RESYNC,
        ST_PENDING
    } state_t;

    localparam logic [8:0] OFF9 = 9'(OFFSET);

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [8:0]        asm_q [4];
    logic [8:0]        asm_d [4];
    logic [8:0]        hold_q [4];
    logic [8:0]        hold_d [4];
    logic              m_valid_q, m_valid_d;
    logic              err_q, err_d;
    logic [ERRW-1:0]   err_cnt_q, err_cnt_d;

    logic              accept;
    logic              load;
    logic              err_event;
    logic [8:0]        sample;

    // s_ready depends only on registered state and reset, never on m_ready
    assign s_ready = !reset && (state_q != ST_PENDING);
    assign accept  = s_valid && s_ready;
    assign sample  = {1'b0, s_data} - OFF9;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        asm_d     = asm_q;
        load      = 1'b0;
        err_event = 1'b0;
        case (state_q)
            ST_COLLECT: begin
                if (accept) begin
                    asm_d[idx_q] = sample;
                    if (idx_q != 2'd3) begin
                        if (s_last) begin
                            idx_d     = 2'd0;
                            err_event = 1'b1;
                        end else begin
                            idx_d = idx_q + 2'd1;
                        end
                    end else begin
                        idx_d = 2'd0;
                        if (s_last) begin
                            state_d = ST_PENDING;
                        end else begin
                            err_event = 1'b1;
                            state_d   = ST_RESYNC;
                        end
                    end
                end
            end
            ST_RESYNC: begin
                if (accept && s_last) begin
                    state_d = ST_COLLECT;
                    idx_d   = 2'd0;
                end
            end
            ST_PENDING: begin
                if (!m_valid_q || m_ready) begin
                    load    = 1'b1;
                    state_d = ST_COLLECT;
                end
            end
            default: begin
                state_d = ST_COLLECT;
                idx_d   = 2'd0;
            end
        endcase
    end

    // a same-cycle load keeps m_valid high so the consumer sees back-to-back vectors
    always_comb begin
        hold_d    = hold_q;
        m_valid_d = m_valid_q;
        if (load) begin
            hold_d    = asm_q;
            m_valid_d = 1'b1;
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    always_comb begin
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (err_clr) begin
            err_d     = 1'b0;
            err_cnt_d = '0;
        end else if (err_event) begin
            err_d = 1'b1;
            if (err_cnt_q != {ERRW{1'b1}}) begin
                err_cnt_d = err_cnt_q + ERRW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_COLLECT;
            idx_q     <= 2'd0;
            m_valid_q <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
            for (int i = 0; i < 4; i++) begin
                asm_q[i]  <= 9'd0;
                hold_q[i] <= 9'd0;
            end
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            m_valid_q <= m_valid_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            asm_q     <= asm_d;
            hold_q    <= hold_d;
        end
    end

    assign x0      = hold_q[0];
    assign x1      = hold_q[1];
    assign x2      = hold_q[2];
    assign x3      = hold_q[3];
    assign m_valid = m_valid_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_nn_input_stage.sv
// tb/tb_nn_input_stage.sv - directed self-checking bench for nn_input_stage
module tb_nn_input_stage;

    logic              clk = 1'b0;
    logic              reset;
    logic [7:0]        s_data;
    logic              s_valid;
    logic              s_last;
    logic              m_ready;
    logic              err_clr;

    logic              s_ready, m_valid, err;
    logic signed [8:0] x0, x1, x2, x3;
    logic [7:0]        err_cnt;

    logic              s_ready_z, m_valid_z, err_z;
    logic signed [8:0] z0, z1, z2, z3;
    logic [7:0]        err_cnt_z;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    nn_input_stage #(.OFFSET(128), .ERRW(8)) dut (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready), .x0(x0), .x1(x1), .x2(x2), .x3(x3), .m_valid(m_valid),
        .m_ready(m_ready), .err_clr(err_clr), .err(err), .err_cnt(err_cnt)
    );

    nn_input_stage #(.OFFSET(0), .ERRW(8)) dut_z (
        .clk(clk), .reset(reset), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
        .s_ready(s_ready_z), .x0(z0), .x1(z1), .x2(z2), .x3(z3), .m_valid(m_valid_z),
        .m_ready(m_ready), .err_clr(err_clr), .err(err_z), .err_cnt(err_cnt_z)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic check_x(input string tag, input int e0, input int e1, input int e2, input int e3);
        check({tag, ".x0"}, 32'($signed(x0)), 32'(e0));
        check({tag, ".x1"}, 32'($signed(x1)), 32'(e1));
        check({tag, ".x2"}, 32'($signed(x2)), 32'(e2));
        check({tag, ".x3"}, 32'($signed(x3)), 32'(e3));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        bit done;
        done    = 0;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        for (int i = 0; i < 20 && !done; i++) begin
            if (s_ready) done = 1;
            step();
        end
        if (!done) check("send_timeout", 32'd0, 32'd1);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] c, input logic [7:0] d);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, 1'b0);
        send(d, 1'b1);
    endtask

    initial begin
        reset   = 1'b1;
        s_data  = 8'd0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b1;
        err_clr = 1'b0;
        step();
        step();
        check("rst.s_ready", 32'(s_ready), 32'd0);
        check("rst.m_valid", 32'(m_valid), 32'd0);
        check_x("rst", 0, 0, 0, 0);
        check("rst.err", 32'(err), 32'd0);
        check("rst.err_cnt", 32'(err_cnt), 32'd0);
        reset = 1'b0;
        step();
        check("post_rst.s_ready", 32'(s_ready), 32'd1);

        // basic frame, both offsets
        send_frame(8'h00, 8'h80, 8'hFF, 8'h7F);
        check("f1.pending_m_valid", 32'(m_valid), 32'd0);
        check("f1.pending_s_ready", 32'(s_ready), 32'd0);
        step();
        check("f1.m_valid", 32'(m_valid), 32'd1);
        check_x("f1", -128, 0, 127, -1);
        check("f1.err", 32'(err), 32'd0);
        check("f1z.x0", 32'($signed(z0)), 32'd0);
        check("f1z.x1", 32'($signed(z1)), 32'd128);
        check("f1z.x2", 32'($signed(z2)), 32'd255);
        check("f1z.x3", 32'($signed(z3)), 32'd127);
        step();
        check("f1.consumed", 32'(m_valid), 32'd0);

        // backpressure with three frames
        m_ready = 1'b0;
        send_frame(8'd10, 8'd11, 8'd12, 8'd13);
        send_frame(8'd20, 8'd21, 8'd22, 8'd23);
        step();
        step();
        check("bp.s_ready", 32'(s_ready), 32'd0);
        check("bp.m_valid", 32'(m_valid), 32'd1);
        check_x("bp.A", -118, -117, -116, -115);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        check("bp.swap_m_valid", 32'(m_valid), 32'd1);
        check("bp.swap_s_ready", 32'(s_ready), 32'd1);
        check_x("bp.B", -108, -107, -106, -105);
        send_frame(8'd30, 8'd31, 8'd32, 8'd33);
        step();
        check("bp.C_held_off", 32'(s_ready), 32'd0);
        check_x("bp.B_kept", -108, -107, -106, -105);
        m_ready = 1'b1;
        step();
        check_x("bp.C", -98, -97, -96, -95);
        step();
        check("bp.drained", 32'(m_valid), 32'd0);

        // short frame then good frame
        send(8'd5, 1'b0);
        send(8'd6, 1'b1);
        check("short.err", 32'(err), 32'd1);
        check("short.err_cnt", 32'(err_cnt), 32'd1);
        send_frame(8'd1, 8'd2, 8'd3, 8'd4);
        step();
        check("short.m_valid", 32'(m_valid), 32'd1);
        check_x("short", -127, -126, -125, -124);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr1.err", 32'(err), 32'd0);
        check("clr1.err_cnt", 32'(err_cnt), 32'd0);

        // long frame: 6 bytes, last on 6th
        for (int i = 0; i < 5; i++) send(8'(40 + i), 1'b0);
        send(8'd45, 1'b1);
        check("long.err", 32'(err), 32'd1);
        check("long.err_cnt", 32'(err_cnt), 32'd1);
        send_frame(8'd20, 8'd21, 8'd22, 8'd23);
        step();
        check("long.m_valid", 32'(m_valid), 32'd1);
        check_x("long", -108, -107, -106, -105);
        check("long.err_cnt_after", 32'(err_cnt), 32'd1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("clr2.err", 32'(err), 32'd0);
        check("clr2.err_cnt", 32'(err_cnt), 32'd0);

        // reset mid-frame with a vector held
        m_ready = 1'b0;
        send_frame(8'd60, 8'd61, 8'd62, 8'd63);
        step();
        check("mid.held", 32'(m_valid), 32'd1);
        send(8'd70, 1'b0);
        send(8'd71, 1'b0);
        reset = 1'b1;
        step();
        check("mid.m_valid", 32'(m_valid), 32'd0);
        check_x("mid.rst", 0, 0, 0, 0);
        check("mid.s_ready", 32'(s_ready), 32'd0);
        reset = 1'b0;
        step();
        m_ready = 1'b1;
        send_frame(8'd50, 8'd51, 8'd52, 8'd53);
        step();
        check("mid.m_valid_after", 32'(m_valid), 32'd1);
        check_x("mid.after", -78, -77, -76, -75);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
